// File: rtl/bram_pipe_sdp.sv
// bram_pipe_sdp: simple-dual-port block RAM, one write and one read port on one
// clock, with a READ_LATENCY-deep read pipeline, byte write strobes, selectable
// read/write collision behaviour and an optional post-reset clear sequencer.
//
// Ports:
//   clock   - rising-edge clock for all logic
//   reset_n - asynchronous active-low reset (memory contents are not reset)
//   ready   - high when ren/wen are accepted
//   ren     - read request, raddr - read address
//   dout    - read data, held while rvalid is low
//   rvalid  - dout carries data for a read accepted READ_LATENCY cycles earlier
//   wen     - write request, wstrb - per-byte enable, waddr/din - write target
module bram_pipe_sdp #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    ADDRESS_WIDTH  = 11,
    parameter int                    BYTE_WIDTH     = 16,
    parameter int                    READ_LATENCY   = 1,
    parameter bit                    WRITE_FIRST    = 1'b0,
    parameter bit                    CLEAR_ON_RESET = 1'b0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter string                 filename       = ""
) (
    input  logic                               clock,
    input  logic                               reset_n,
    output logic                               ready,
    input  logic                               ren,
    input  logic [ADDRESS_WIDTH-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]              dout,
    output logic                               rvalid,
    input  logic                               wen,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wstrb,
    input  logic [ADDRESS_WIDTH-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]              din
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

    // Elaboration-time parameter checks.
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
        $error("bram_pipe_sdp: BYTE_WIDTH must divide DATA_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("bram_pipe_sdp: READ_LATENCY must be in 1..4");
    end
    // The clear sequencer overwrites every word, so a preload file would
    // be lost; preloading is done by the simulation harness on mem_q.
    if (CLEAR_ON_RESET && (filename != "")) begin : g_file_ignored
        $warning("bram_pipe_sdp: filename ignored when CLEAR_ON_RESET=1");
    end

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    // Reset parks the FSM in the state it must occupy on release, so the
    // clear starts in the very first cycle after reset_n rises.
    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

    (* ram_style = "block" *)
    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

    logic                     clr_we;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0]    wd;
    logic [NB-1:0]            ws;
    logic                     rd_acc;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic [DATA_WIDTH-1:0]    rd_fwd;

    logic [DATA_WIDTH-1:0]    pipe_q [READ_LATENCY];
    logic [READ_LATENCY-1:0]  vld_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDRESS_WIDTH'(DEPTH - 1)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // ready is forced low while reset_n is held, even in the READY state.
    assign ready  = reset_n && (state_q == S_READY);
    assign clr_we = reset_n && (state_q == S_CLEAR);
    assign rd_acc = ready && ren;

    // ---------------- write port ----------------
    // The clear sequencer shares the single write port.
    always_comb begin
        we = clr_we || (ready && wen);
        wa = waddr;
        wd = din;
        ws = wstrb;
        if (clr_we) begin
            wa = cnt_q;
            wd = CLEAR_VALUE;
            ws = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (ws[b]) begin
                    mem_q[wa][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                        wd[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ---------------- read port ----------------
    assign rd_word = mem_q[raddr];

    // Write-first: bytes being written this cycle to the read address are
    // forwarded; untouched bytes come from the array.
    always_comb begin
        rd_fwd = rd_word;
        if (WRITE_FIRST && we && (wa == raddr)) begin
            for (int b = 0; b < NB; b++) begin
                if (ws[b]) begin
                    rd_fwd[b*BYTE_WIDTH +: BYTE_WIDTH] =
                        wd[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Each stage loads only behind a valid token, so the last stage keeps
    // the most recent read data while rvalid is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                pipe_q[0] <= rd_fwd;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end

    assign rvalid = vld_q[READ_LATENCY-1];
    assign dout   = pipe_q[READ_LATENCY-1];

endmodule

// File: tb/tb_bram_pipe_sdp.sv
// tb_bram_pipe_sdp: two bram_pipe_sdp instances (latency 2 read-first and
// latency 3 write-first) on shared stimulus, checked against a word-array model.
module tb_bram_pipe_sdp;

    localparam int          MAXC  = 1024;
    localparam int          DEPTH = 16;
    localparam logic [15:0] CV    = 16'hA5A5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [3:0]  raddr = '0, waddr = '0;
    logic [1:0]  wstrb = '0;
    logic [15:0] din = '0;
    logic        ready_a, ready_b, rvalid_a, rvalid_b;
    logic [15:0] dout_a, dout_b;

    always #5 clock = ~clock;

    bram_pipe_sdp #(
        .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .WRITE_FIRST(1'b0),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV), .filename("")
    ) u_a (
        .clock(clock), .reset_n(reset_n), .ready(ready_a),
        .ren(ren), .raddr(raddr), .dout(dout_a), .rvalid(rvalid_a),
        .wen(wen), .wstrb(wstrb), .waddr(waddr), .din(din)
    );

    bram_pipe_sdp #(
        .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(3), .WRITE_FIRST(1'b1),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV), .filename("")
    ) u_b (
        .clock(clock), .reset_n(reset_n), .ready(ready_b),
        .ren(ren), .raddr(raddr), .dout(dout_b), .rvalid(rvalid_b),
        .wen(wen), .wstrb(wstrb), .waddr(waddr), .din(din)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;
    bit prev_rst = 1'b0;
    bit rst_drv = 1'b0;

    // reference model
    logic [15:0] mem_m [DEPTH];
    bit          sva [MAXC];
    bit          svb [MAXC];
    logic [15:0] sda [MAXC];
    logic [15:0] sdb [MAXC];
    bit          erdy [MAXC];
    logic [15:0] eha [MAXC];
    logic [15:0] ehb [MAXC];
    logic [15:0] ha = '0, hb = '0;

    // observed
    logic        rdy_a [MAXC];
    logic        rdy_b [MAXC];
    logic        rva [MAXC];
    logic        rvb [MAXC];
    logic [15:0] doa [MAXC];
    logic [15:0] dob [MAXC];

    function automatic logic [15:0] merge(input logic [15:0] old,
                                          input logic [15:0] wd,
                                          input logic [1:0]  ws);
        logic [15:0] r;
        r = old;
        if (ws[0]) r[7:0]  = wd[7:0];
        if (ws[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // then advance the model by what the rising edge will do.
    task automatic run_cycle(input logic re, input logic [3:0] ra,
                             input logic we, input logic [1:0] ws,
                             input logic [3:0] wa, input logic [15:0] wd);
        bit          mready;
        logic [15:0] old;
        if (cyc + 6 >= MAXC) begin
            $display("FAIL cycle_budget cyc %0d limit %0d", cyc, MAXC);
            $fatal(1);
        end
        @(negedge clock);
        reset_n = rst_drv;
        ren = re; raddr = ra; wen = we; wstrb = ws; waddr = wa; din = wd;
        #1;
        rdy_a[cyc] = ready_a; rdy_b[cyc] = ready_b;
        rva[cyc] = rvalid_a;  rvb[cyc] = rvalid_b;
        doa[cyc] = dout_a;    dob[cyc] = dout_b;
        if (!reset_n) begin
            for (int k = 0; k < 5; k++) begin
                sva[cyc+k] = 1'b0;
                svb[cyc+k] = 1'b0;
            end
            ha = '0;
            hb = '0;
        end else if (!prev_rst) begin
            rel = cyc;
            for (int k = 0; k < DEPTH; k++) mem_m[k] = CV;
        end
        mready = reset_n && ((cyc - rel) >= DEPTH);
        erdy[cyc] = mready;
        if (sva[cyc]) ha = sda[cyc];
        if (svb[cyc]) hb = sdb[cyc];
        eha[cyc] = ha;
        ehb[cyc] = hb;
        if (mready && re) begin
            old = mem_m[ra];
            sva[cyc+2] = 1'b1;
            sda[cyc+2] = old;
            svb[cyc+3] = 1'b1;
            sdb[cyc+3] = (we && wa == ra) ? merge(old, wd, ws) : old;
        end
        if (mready && we) mem_m[wa] = merge(mem_m[wa], wd, ws);
        prev_rst = reset_n;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        int c0, r;
        bit any_v;
        c0 = cyc;
        rst_drv = 1'b0;
        idle(3);
        rst_drv = 1'b1;
        r = cyc;
        for (int i = 0; i < 16; i++)
            run_cycle(1'b1, 4'(i), i == 5, 2'b11, 4'd2, 16'h1111);
        idle(4);
        for (int i = 0; i < 16; i++)
            run_cycle(1'b1, 4'(i), 1'b0, '0, '0, '0);
        idle(4);
        checks++;
        if (rdy_a[r+15] !== 1'b0 || rdy_b[r+15] !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready_low got %b/%b want 0", rdy_a[r+15], rdy_b[r+15]);
        end
        checks++;
        if (rdy_a[r+16] !== 1'b1 || rdy_b[r+16] !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready_rise got %b/%b want 1", rdy_a[r+16], rdy_b[r+16]);
        end
        any_v = 1'b0;
        for (int c = r; c < r + 20; c++) any_v |= (rva[c] | rvb[c]);
        checks++;
        if (any_v !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_rvalid got %b want 0", any_v);
        end
        checks++;
        if (doa[r+24] !== CV) begin
            errors++;
            $display("FAIL clear_wen_ignored got %h want %h", doa[r+24], CV);
        end
        for (int c = c0; c < cyc; c++) begin
            checks += 5;
            if (rdy_a[c] !== erdy[c] || rdy_b[c] !== erdy[c]) begin
                errors++; $display("FAIL reset_ready c%0d got %b/%b want %b", c, rdy_a[c], rdy_b[c], erdy[c]);
            end
            if (rva[c] !== sva[c]) begin errors++; $display("FAIL reset_rvalid_a c%0d got %b want %b", c, rva[c], sva[c]); end
            if (rvb[c] !== svb[c]) begin errors++; $display("FAIL reset_rvalid_b c%0d got %b want %b", c, rvb[c], svb[c]); end
            if (doa[c] !== eha[c]) begin errors++; $display("FAIL reset_dout_a c%0d got %h want %h", c, doa[c], eha[c]); end
            if (dob[c] !== ehb[c]) begin errors++; $display("FAIL reset_dout_b c%0d got %h want %h", c, dob[c], ehb[c]); end
        end
    endtask

    task automatic test_write_read();
        int t;
        t = cyc;
        run_cycle(1'b0, '0, 1'b1, 2'b11, 4'd3, 16'h1234);
        run_cycle(1'b1, 4'd3, 1'b0, '0, '0, '0);
        idle(5);
        checks++;
        if (rva[t+3] !== 1'b1 || doa[t+3] !== 16'h1234) begin
            errors++; $display("FAIL wr_rd_a got %b/%h want 1/1234", rva[t+3], doa[t+3]);
        end
        checks++;
        if (rva[t+4] !== 1'b0 || doa[t+4] !== 16'h1234) begin
            errors++; $display("FAIL wr_rd_hold_a got %b/%h want 0/1234", rva[t+4], doa[t+4]);
        end
        checks++;
        if (rvb[t+3] !== 1'b0 || rvb[t+4] !== 1'b1 || dob[t+4] !== 16'h1234) begin
            errors++; $display("FAIL wr_rd_b got %b%b/%h want 01/1234", rvb[t+3], rvb[t+4], dob[t+4]);
        end
    endtask

    task automatic test_byte_strobe();
        int t;
        t = cyc;
        run_cycle(1'b0, '0, 1'b1, 2'b11, 4'd5, 16'hBEEF);
        run_cycle(1'b0, '0, 1'b1, 2'b01, 4'd5, 16'h1122);
        run_cycle(1'b0, '0, 1'b1, 2'b00, 4'd5, 16'h7777);
        run_cycle(1'b1, 4'd5, 1'b0, '0, '0, '0);
        idle(5);
        checks++;
        if (rva[t+5] !== 1'b1 || doa[t+5] !== 16'hBE22) begin
            errors++; $display("FAIL strobe_a got %b/%h want 1/be22", rva[t+5], doa[t+5]);
        end
        checks++;
        if (rvb[t+6] !== 1'b1 || dob[t+6] !== 16'hBE22) begin
            errors++; $display("FAIL strobe_b got %b/%h want 1/be22", rvb[t+6], dob[t+6]);
        end
    endtask

    task automatic test_collision();
        int t;
        t = cyc;
        run_cycle(1'b0, '0, 1'b1, 2'b11, 4'd7, 16'h0001);
        run_cycle(1'b1, 4'd7, 1'b1, 2'b11, 4'd7, 16'h00FF);
        run_cycle(1'b1, 4'd7, 1'b0, '0, '0, '0);
        idle(5);
        checks++;
        if (doa[t+3] !== 16'h0001) begin
            errors++; $display("FAIL collide_read_first got %h want 0001", doa[t+3]);
        end
        checks++;
        if (dob[t+4] !== 16'h00FF) begin
            errors++; $display("FAIL collide_write_first got %h want 00ff", dob[t+4]);
        end
        checks++;
        if (doa[t+4] !== 16'h00FF || dob[t+5] !== 16'h00FF) begin
            errors++; $display("FAIL collide_after got %h/%h want 00ff", doa[t+4], dob[t+5]);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        logic [15:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = 16'($urandom);
            run_cycle(1'b0, '0, 1'b1, 2'b11, 4'(i), v[i]);
        end
        t = cyc;
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 4'(i), 1'b0, '0, '0, '0);
        idle(6);
        checks++;
        if (rvb[t+2] !== 1'b0 || rvb[t+7] !== 1'b0) begin
            errors++; $display("FAIL b2b_window got %b/%b want 0/0", rvb[t+2], rvb[t+7]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rvb[t+3+i] !== 1'b1 || dob[t+3+i] !== v[i]) begin
                errors++; $display("FAIL b2b_data%0d got %b/%h want 1/%h", i, rvb[t+3+i], dob[t+3+i], v[i]);
            end
        end
    endtask

    task automatic test_random();
        int c0;
        logic [3:0] m;
        c0 = cyc;
        for (int i = 0; i < 150; i++) begin
            m = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'hF;
            run_cycle(1'($urandom), 4'($urandom) & m, 1'($urandom),
                      2'($urandom), 4'($urandom) & m, 16'($urandom));
        end
        idle(5);
        for (int c = c0; c < cyc; c++) begin
            checks += 5;
            if (rdy_a[c] !== erdy[c] || rdy_b[c] !== erdy[c]) begin
                errors++; $display("FAIL rand_ready c%0d got %b/%b want %b", c, rdy_a[c], rdy_b[c], erdy[c]);
            end
            if (rva[c] !== sva[c]) begin errors++; $display("FAIL rand_rvalid_a c%0d got %b want %b", c, rva[c], sva[c]); end
            if (rvb[c] !== svb[c]) begin errors++; $display("FAIL rand_rvalid_b c%0d got %b want %b", c, rvb[c], svb[c]); end
            if (doa[c] !== eha[c]) begin errors++; $display("FAIL rand_dout_a c%0d got %h want %h", c, doa[c], eha[c]); end
            if (dob[c] !== ehb[c]) begin errors++; $display("FAIL rand_dout_b c%0d got %h want %h", c, dob[c], ehb[c]); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int c0, r0, r;
        c0 = cyc;
        for (int i = 0; i < 16; i++)
            run_cycle(1'b0, '0, 1'b1, 2'b11, 4'(i), 16'h0F00 + 16'(i));
        r0 = cyc;
        run_cycle(1'b1, 4'd9, 1'b0, '0, '0, '0);
        idle(2);
        checks++;
        if (rva[r0+2] !== 1'b1 || doa[r0+2] !== 16'h0F09) begin
            errors++; $display("FAIL pre_reset_read got %b/%h want 1/0f09", rva[r0+2], doa[r0+2]);
        end
        #2;
        rst_drv = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rvalid_a !== 1'b0 || dout_a !== 16'h0 || rvalid_b !== 1'b0 || dout_b !== 16'h0) begin
            errors++; $display("FAIL async_reset got %b/%h %b/%h want 0/0000", rvalid_a, dout_a, rvalid_b, dout_b);
        end
        checks++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            errors++; $display("FAIL async_reset_ready got %b/%b want 0", ready_a, ready_b);
        end
        idle(2);
        rst_drv = 1'b1;
        idle(6);
        rst_drv = 1'b0;
        idle(2);
        rst_drv = 1'b1;
        r = cyc;
        for (int i = 0; i < 16; i++)
            run_cycle(1'b1, 4'(i), 1'b1, 2'b11, 4'(i), 16'h5555);
        for (int i = 0; i < 16; i++)
            run_cycle(1'b1, 4'(i), 1'b0, '0, '0, '0);
        idle(4);
        checks++;
        if (rdy_a[r+15] !== 1'b0 || rdy_a[r+16] !== 1'b1) begin
            errors++; $display("FAIL reclear_ready got %b%b want 01", rdy_a[r+15], rdy_a[r+16]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (doa[r+18+i] !== CV) begin
                errors++; $display("FAIL reclear_word%0d got %h want %h", i, doa[r+18+i], CV);
            end
        end
        for (int c = c0; c < cyc; c++) begin
            checks += 5;
            if (rdy_a[c] !== erdy[c] || rdy_b[c] !== erdy[c]) begin
                errors++; $display("FAIL mid_ready c%0d got %b/%b want %b", c, rdy_a[c], rdy_b[c], erdy[c]);
            end
            if (rva[c] !== sva[c]) begin errors++; $display("FAIL mid_rvalid_a c%0d got %b want %b", c, rva[c], sva[c]); end
            if (rvb[c] !== svb[c]) begin errors++; $display("FAIL mid_rvalid_b c%0d got %b want %b", c, rvb[c], svb[c]); end
            if (doa[c] !== eha[c]) begin errors++; $display("FAIL mid_dout_a c%0d got %h want %h", c, doa[c], eha[c]); end
            if (dob[c] !== ehb[c]) begin errors++; $display("FAIL mid_dout_b c%0d got %h want %h", c, dob[c], ehb[c]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
